uart_cmd_framer: RTL and testbench
==================================

# uart_cmd_framer

Sits directly downstream of the UART receiver and upstream of the UART transmitter. Assembles three consecutive received bytes (opcode, data high, data low) into one command word with a sticky ready flag for the command processor. Also issues single-byte responses back through the transmitter with a busy/done handshake. Bridges byte-level serial traffic and word-level command handling.

## Interface
- `TIMEOUT_CYC`, default 50000: inter-byte timeout in clocks; used only when `CMD_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_rdy`  in  1  byte-available flag from UART receiver.
- `rx_data`  in  8  received byte.
- `clr_rx_rdy`  out  1  acknowledge to receiver; consumes the current byte.
- `cmd_rdy`  out  1  sticky: complete command available.
- `cmd`  out  8  opcode (byte 0).
- `data`  out  16  payload: {byte 1, byte 2}.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy`.
- `send_resp`  in  1  request to transmit `resp`.
- `resp`  in  8  response byte.
- `trmt`  out  1  one-cycle start pulse to UART transmitter.
- `tx_data`  out  8  byte to transmitter, registered.
- `tx_done`  in  1  transmitter completion flag.
- `resp_busy`  out  1  response in flight.
- `resp_sent`  out  1  one-cycle pulse when the response completes.
- `frame_err`  out  1  one-cycle pulse on partial-frame timeout. Always 0 without `CMD_TIMEOUT_EN`.

## Operation
- Receive FSM states: `WAIT_OP` → `WAIT_HI` → `WAIT_LO` → `WAIT_OP`. It advances only in a cycle with `rx_rdy`=1.
- Byte capture, in any state with `rx_rdy`=1:
  - `clr_rx_rdy`=1 combinationally in that same cycle.
  - The byte is registered at the clock edge.
  - `rx_data` is never sampled again until `rx_rdy` deasserts and re-asserts.
- Per state:
  - `WAIT_OP` capture: load opcode into a shadow register and clear `cmd_rdy` (a new frame starts).
  - `WAIT_HI` capture: load shadow high byte.
  - `WAIT_LO` capture: load `data[7:0]`, transfer shadow into `cmd`/`data[15:8]`, and set `cmd_rdy`.
- `cmd` and `data` change only on completion of a frame; they are stable while `cmd_rdy`=1.
- `cmd_rdy` priority: a set in the same cycle as `clr_cmd_rdy` means set wins. A `WAIT_OP` capture clears it.
- Response path:
  - `send_resp`=1 while `resp_busy`=0: next cycle `trmt`=1 for exactly one cycle, `tx_data`=`resp`, `resp_busy`=1.
  - `send_resp` while `resp_busy`=1 is ignored (dropped, no queue).
  - `tx_done`=1 while `resp_busy`=1 and `trmt`=0: `resp_busy`→0 and `resp_sent` pulses for one cycle.
  - `tx_done` while idle is ignored.
- Reset values: state `WAIT_OP`; `cmd_rdy`, `cmd`, `data`, `trmt`, `tx_data`, `resp_busy`, `resp_sent`, `frame_err` all 0.
- `clr_rx_rdy` is combinational; it is 0 whenever `rst`=1.
- Reset mid-frame discards the partial frame; reset mid-response drops `resp_busy` without `resp_sent`.

## Timing
- Command latency: `cmd_rdy` is high the cycle after the cycle in which byte 2 is acknowledged.
- Back-to-back bytes on consecutive cycles are legal; one byte is captured per `rx_rdy` high cycle.
- `send_resp` to `trmt`: 1 cycle.
- `tx_done` to `resp_sent`: 1 cycle.
- Receive and response paths are independent; they may be active in the same cycle.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A 16-bit counter clears on every captured byte and increments while in `WAIT_HI` or `WAIT_LO`.
  - On reaching `TIMEOUT_CYC`-1 with no capture, the FSM returns to `WAIT_OP` and `frame_err` pulses one cycle.
  - `cmd_rdy`, `cmd` and `data` are untouched by a timeout.
  - A capture in the same cycle as expiry wins: no error, and the FSM advances.
- Not defined: no counter; the FSM waits indefinitely; `frame_err` is tied 0.

## Test plan
- Reset, then bytes 0xA5, 0x12, 0x34 -> `cmd`=0xA5, `data`=0x1234, `cmd_rdy`=1 one cycle after third ack. `clr_rx_rdy` is high exactly 3 cycles.
- `cmd_rdy`=1, assert `clr_cmd_rdy` -> `cmd_rdy`=0 next cycle. Repeat with `clr_cmd_rdy` coincident with the frame-completing byte -> `cmd_rdy`=1.
- Second frame 0x05, 0xFF, 0x00 without clearing -> `cmd_rdy` falls on 0x05 ack, rises with `cmd`=0x05 and `data`=0xFF00. The first frame's `cmd`/`data` hold until then.
- `send_resp` with `resp`=0xA5 -> `trmt` one-cycle pulse, `tx_data`=0xA5. Second `send_resp` with 0x5A while busy -> no `trmt`. `tx_done` -> `resp_sent` pulse, `resp_busy`=0.
- With `CMD_TIMEOUT_EN`, `TIMEOUT_CYC`=20: send 0x11, then idle 20 cycles -> `frame_err` pulse and state `WAIT_OP`. Then 0x22, 0x33, 0x44 -> `cmd`=0x22, `data`=0x3344.
- Assert `rst` after byte 1 of a frame -> all outputs 0. Next three bytes form a clean frame.

Source files
------------

// File: rtl/uart_cmd_framer.sv
// Frames opcode/data-high/data-low UART bytes into a command word and runs a
// single-byte response handshake. Optional inter-byte timeout: CMD_TIMEOUT_EN.
module uart_cmd_framer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_busy,
  output logic        resp_sent,
  output logic        frame_err
);

  typedef enum logic [1:0] {WAIT_OP, WAIT_HI, WAIT_LO} rx_state_t;

  rx_state_t  state, state_nxt;
  logic       capture;
  logic       ld_op, ld_hi, ld_lo;
  logic       expire;
  logic [7:0] op_sh, hi_sh;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_OP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (capture) begin
      case (state)
        WAIT_OP: state_nxt = WAIT_HI;
        WAIT_HI: state_nxt = WAIT_LO;
        default: state_nxt = WAIT_OP;
      endcase
    end else if (expire) begin
      state_nxt = WAIT_OP;
    end
  end

  always_comb begin
    capture    = rx_rdy && !rst;
    clr_rx_rdy = capture;
    ld_op      = capture && (state == WAIT_OP);
    ld_hi      = capture && (state == WAIT_HI);
    ld_lo      = capture && (state == WAIT_LO);
  end

`ifdef CMD_TIMEOUT_EN
  logic [15:0] to_cnt;

  // A capture in the expiry cycle takes precedence, so expiry requires !capture.
  assign expire = (state != WAIT_OP) && !capture &&
                  (to_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || capture || expire) to_cnt <= '0;
    else if (state != WAIT_OP)    to_cnt <= to_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= expire;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign expire    = 1'b0;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_sh <= '0;
      hi_sh <= '0;
      cmd   <= '0;
      data  <= '0;
    end else begin
      if (ld_op) op_sh <= rx_data;
      if (ld_hi) hi_sh <= rx_data;
      if (ld_lo) begin
        cmd  <= op_sh;
        data <= {hi_sh, rx_data};
      end
    end
  end

  // Completion outranks both the consumer clear and a new-frame clear.
  always_ff @(posedge clk) begin
    if (rst)                       cmd_rdy <= 1'b0;
    else if (ld_lo)                cmd_rdy <= 1'b1;
    else if (ld_op || clr_cmd_rdy) cmd_rdy <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trmt      <= 1'b0;
      tx_data   <= '0;
      resp_busy <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      if (send_resp && !resp_busy) begin
        trmt      <= 1'b1;
        tx_data   <= resp;
        resp_busy <= 1'b1;
      end else if (tx_done && resp_busy && !trmt) begin
        resp_busy <= 1'b0;
        resp_sent <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed plus randomized bench for uart_cmd_framer against a byte-list
// reference model; timeout expectations follow CMD_TIMEOUT_EN.
module tb_uart_cmd_framer;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = '0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        resp_busy;
  logic        resp_sent;
  logic        frame_err;

  uart_cmd_framer #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .resp_busy(resp_busy), .resp_sent(resp_sent), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: bytes collected into the current frame, plus handshake flags.
  logic [7:0]  fr [3];
  int unsigned pos = 0;
  int unsigned idle_cnt = 0;
  logic        m_rdy = 1'b0;
  logic [7:0]  m_cmd = '0;
  logic [15:0] m_data = '0;
  logic        m_trmt = 1'b0;
  logic [7:0]  m_txd = '0;
  logic        m_busy = 1'b0;
  logic        m_sent = 1'b0;
  logic        m_ferr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic busy_old, trmt_old;
    busy_old = m_busy;
    trmt_old = m_trmt;
    m_ferr = 1'b0;
    m_trmt = 1'b0;
    m_sent = 1'b0;
    if (rst) begin
      pos = 0; idle_cnt = 0; m_rdy = 1'b0; m_cmd = '0; m_data = '0;
      m_txd = '0; m_busy = 1'b0;
      return;
    end
    if (rx_rdy) begin
      fr[pos] = rx_data;
      idle_cnt = 0;
      if (pos == 2) begin
        m_cmd = fr[0];
        m_data = {fr[1], fr[2]};
        m_rdy = 1'b1;
        pos = 0;
      end else begin
        if (pos == 0 || clr_cmd_rdy) m_rdy = 1'b0;
        pos++;
      end
    end else begin
      if (clr_cmd_rdy) m_rdy = 1'b0;
`ifdef CMD_TIMEOUT_EN
      if (pos != 0) begin
        idle_cnt++;
        if (idle_cnt == TO) begin
          pos = 0;
          idle_cnt = 0;
          m_ferr = 1'b1;
        end
      end
`endif
    end
    if (send_resp && !busy_old) begin
      m_trmt = 1'b1;
      m_txd = resp;
      m_busy = 1'b1;
    end else if (tx_done && busy_old && !trmt_old) begin
      m_busy = 1'b0;
      m_sent = 1'b1;
    end
  endtask

  // One clock: inputs already applied; check the combinational ack, advance, check registers.
  task automatic cycle();
    #1;
    chk("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, rx_rdy && !rst});
    model_step();
    @(posedge clk);
    #1;
    chk("cmd_rdy",   {31'd0, cmd_rdy},   {31'd0, m_rdy});
    chk("cmd",       {24'd0, cmd},       {24'd0, m_cmd});
    chk("data",      {16'd0, data},      {16'd0, m_data});
    chk("trmt",      {31'd0, trmt},      {31'd0, m_trmt});
    chk("tx_data",   {24'd0, tx_data},   {24'd0, m_txd});
    chk("resp_busy", {31'd0, resp_busy}, {31'd0, m_busy});
    chk("resp_sent", {31'd0, resp_sent}, {31'd0, m_sent});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
  endtask

  task automatic quiet();
    rst = 1'b0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    quiet();
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr);
    quiet();
    rx_rdy = 1'b1; rx_data = b; clr_cmd_rdy = clr;
    cycle();
    quiet();
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    cycle();
    cycle();
    quiet();
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);

    // First frame with single-cycle gaps, then consumer clear.
    send_byte(8'hA5, 1'b0); idle(1);
    send_byte(8'h12, 1'b0); idle(1);
    send_byte(8'h34, 1'b0);
    chk("frame1_cmd",  {24'd0, cmd},  32'h0000_00A5);
    chk("frame1_data", {16'd0, data}, 32'h0000_1234);
    idle(2);
    clr_cmd_rdy = 1'b1; cycle(); quiet();
    chk("clr_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);

    // Back-to-back bytes; clear coincident with completion loses.
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h99, 1'b1);
    chk("set_wins", {31'd0, cmd_rdy}, 32'd1);
    idle(1);

    // Second frame without clearing: rdy drops on opcode, old word held.
    send_byte(8'h05, 1'b0);
    chk("new_frame_clr", {31'd0, cmd_rdy}, 32'd0);
    chk("hold_cmd", {24'd0, cmd}, 32'h0000_0077);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("frame2_word", {8'd0, cmd, data}, 32'h0005_FF00);

    // Response path: request, dropped request while busy, stray done ignored.
    tx_done = 1'b1; cycle(); quiet();
    send_resp = 1'b1; resp = 8'hA5; cycle(); quiet();
    chk("trmt_pulse", {23'd0, trmt, tx_data}, 32'h0000_01A5);
    send_resp = 1'b1; resp = 8'h5A; cycle(); quiet();
    chk("busy_drop", {31'd0, trmt}, 32'd0);
    idle(3);
    tx_done = 1'b1; cycle(); quiet();
    chk("resp_sent", {30'd0, resp_sent, resp_busy}, 32'd2);
    idle(1);

    // Partial frame followed by a long idle.
    send_byte(8'h11, 1'b0);
    idle(TO);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
`ifdef CMD_TIMEOUT_EN
    chk("timeout_frame", {8'd0, cmd, data}, 32'h0022_3344);
`else
    chk("no_timeout_frame", {8'd0, cmd, data}, 32'h0011_2233);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
`endif
    idle(1);

    // Reset mid-frame and mid-response.
    send_resp = 1'b1; resp = 8'h3C; cycle(); quiet();
    send_byte(8'hDE, 1'b0);
    do_reset();
    chk("rst_outputs", {cmd_rdy, trmt, resp_busy, resp_sent, frame_err, 3'd0, cmd, data}, 32'd0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h81, 1'b0);
    send_byte(8'h7E, 1'b0);
    chk("post_rst_frame", {7'd0, cmd_rdy, cmd, data}, 32'h01C3_817E);

    // Randomized traffic on both paths, including long gaps and rare resets.
    for (int unsigned i = 0; i < 600; i++) begin
      quiet();
      if ($urandom_range(0, 39) == 0) begin
        idle($urandom_range(TO - 3, TO + 3));
        quiet();
      end
      rst         = ($urandom_range(0, 99) == 0);
      rx_rdy      = ($urandom_range(0, 2) == 0);
      rx_data     = 8'($urandom);
      clr_cmd_rdy = ($urandom_range(0, 7) == 0);
      send_resp   = ($urandom_range(0, 5) == 0);
      resp        = 8'($urandom);
      tx_done     = ($urandom_range(0, 4) == 0);
      cycle();
    end
    quiet();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
